ov7670_config_seq: RTL and testbench



---
 rtl/ov7670_cfg_pkg.sv | 27 ++
 rtl/cfg_delay_timer.sv | 40 ++++
 rtl/ov7670_config_seq.sv | 197 +++++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_pkg
// Constants and types shared by the OV7670 config ROM and its sequencer.
//   CFG_END   : ROM entry that terminates configuration
//   CFG_DELAY : ROM entry that inserts a fixed settle delay
//   ROM_AW    : ROM address width
//   CFG_DW    : ROM entry width, {reg[15:8], val[7:0]}
//   cfg_state_t : sequencer states
// ---------------------------------------------------------------------------
package ov7670_cfg_pkg;

   localparam int ROM_AW = 8;
   localparam int CFG_DW = 16;

   localparam logic [CFG_DW-1:0] CFG_END   = 16'hFFFF;
   localparam logic [CFG_DW-1:0] CFG_DELAY = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      WRITE,
      DELAY,
      DONE
   } cfg_state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// ---------------------------------------------------------------------------
// cfg_delay_timer
// Down-counter for the config settle delay. load presets the counter to
// DELAY_CYCLES-1; en decrements it (saturating at zero). expired is high
// while the count is zero, so a load followed by en for DELAY_CYCLES cycles
// sees expired on the last of those cycles.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : preset counter to DELAY_CYCLES-1
//   en         : decrement
//   expired    : counter at zero
// ---------------------------------------------------------------------------
module cfg_delay_timer #(
   parameter int DELAY_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// ---------------------------------------------------------------------------
// ov7670_config_seq
// Walks the OV7670 config ROM from address 0 and turns each entry into one
// SCCB register write (valid/ready). CFG_DELAY entries insert a settle
// delay of DELAY_CYCLES clocks; CFG_END (or the last ROM address) finishes.
//
// Optional build macro OV7670_CFG_TIMEOUT_EN: adds output err and a stall
// limit of TIMEOUT_CYCLES on sccb_ready; on expiry the write is abandoned
// and the sequencer finishes with err=1.
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : pulse, begin/restart (ignored while busy)
//   rom_en, rom_addr     : ROM clock enable and address
//   rom_dout             : ROM data, valid the cycle after rom_en
//   sccb_valid/reg/data  : register-write request to the SCCB master
//   sccb_ready           : SCCB master accepts request
//   busy, done           : configuration in progress / complete
//   err                  : (optional) aborted on sccb_ready stall
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// FETCH  | rom_en high, ROM registers entry at rom_addr
// DECODE | classify rom_dout: write, delay or end
// WRITE  | request held until valid&&ready
// DELAY  | settle timer running
// DONE   | configuration finished, waiting for start to rerun
// ---------------------------------------------------------------------------
module ov7670_config_seq
   import ov7670_cfg_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 25_000_000,
   parameter int DELAY_US     = 10_000,
   parameter int DELAY_CYCLES = CLK_FREQ_HZ / 1_000_000 * DELAY_US
`ifdef OV7670_CFG_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [CFG_DW-1:0] rom_dout,
   output logic              sccb_valid,
   output logic [7:0]        sccb_reg,
   output logic [7:0]        sccb_data,
   input  logic              sccb_ready,
   output logic              busy,
   output logic              done
`ifdef OV7670_CFG_TIMEOUT_EN
   ,
   output logic              err
`endif
);

   cfg_state_t state;
   logic       tmr_load;
   logic       tmr_en;
   logic       tmr_expired;
   logic       last_addr;

`ifdef OV7670_CFG_TIMEOUT_EN
   localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
   logic [SW-1:0] stall_cnt;
`endif

   assign tmr_load  = (state == DECODE) && (rom_dout == CFG_DELAY);
   assign tmr_en    = (state == DELAY);
   assign last_addr = (rom_addr == {ROM_AW{1'b1}});

   cfg_delay_timer #(
      .DELAY_CYCLES(DELAY_CYCLES)
   ) u_delay_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // rom_en is registered, so it is raised on every transition into FETCH
   // and dropped on the way out; the ROM then captures on the edge that
   // ends FETCH and DECODE sees fresh data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_en     <= 1'b0;
         rom_addr   <= '0;
         sccb_valid <= 1'b0;
         sccb_reg   <= '0;
         sccb_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef OV7670_CFG_TIMEOUT_EN
         err        <= 1'b0;
         stall_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rom_addr <= '0;
                  rom_en   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end

            FETCH: begin
               rom_en <= 1'b0;
               state  <= DECODE;
            end

            DECODE: begin
               if (rom_dout == CFG_END) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (rom_dout == CFG_DELAY) begin
                  state <= DELAY;
               end else begin
                  sccb_reg   <= rom_dout[15:8];
                  sccb_data  <= rom_dout[7:0];
                  sccb_valid <= 1'b1;
`ifdef OV7670_CFG_TIMEOUT_EN
                  stall_cnt  <= '0;
`endif
                  state      <= WRITE;
               end
            end

            WRITE: begin
               if (sccb_ready) begin
                  sccb_valid <= 1'b0;
                  // The last ROM address finishes the sequence; no wrap.
                  if (last_addr) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     rom_en   <= 1'b1;
                     state    <= FETCH;
                  end
               end
`ifdef OV7670_CFG_TIMEOUT_EN
               else if (stall_cnt == STALL_LAST) begin
                  sccb_valid <= 1'b0;
                  err        <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  stall_cnt <= stall_cnt + SW'(1);
               end
`endif
            end

            DELAY: begin
               if (tmr_expired) begin
                  if (last_addr) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     rom_en   <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end

            DONE: begin
               if (start) begin
                  done     <= 1'b0;
`ifdef OV7670_CFG_TIMEOUT_EN
                  err      <= 1'b0;
`endif
                  busy     <= 1'b1;
                  rom_addr <= '0;
                  rom_en   <= 1'b1;
                  state    <= FETCH;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// ---------------------------------------------------------------------------
// tb_ov7670_config_seq
// Self-checking bench: a ROM model feeds the sequencer; the expected write
// list, inter-write spacing and final address are derived from the ROM
// contents alone (walk entries, skip delays, stop at end marker or 255).
// ---------------------------------------------------------------------------
module tb_ov7670_config_seq;
   import ov7670_cfg_pkg::*;

   localparam int DC = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rom_en;
   logic [7:0]  rom_addr;
   logic [15:0] rom_dout = '0;
   logic        sccb_valid;
   logic [7:0]  sccb_reg;
   logic [7:0]  sccb_data;
   logic        sccb_ready;
   logic        busy;
   logic        done;
`ifdef OV7670_CFG_TIMEOUT_EN
   logic        err;
`endif

   always #5 clk = ~clk;

   ov7670_config_seq #(
      .DELAY_CYCLES(DC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_dout   (rom_dout),
      .sccb_valid (sccb_valid),
      .sccb_reg   (sccb_reg),
      .sccb_data  (sccb_data),
      .sccb_ready (sccb_ready),
      .busy       (busy),
      .done       (done)
`ifdef OV7670_CFG_TIMEOUT_EN
      ,
      .err        (err)
`endif
   );

   // ROM model: registers dout on the edge where rom_en is high.
   logic [15:0] rom [256];
   always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

   // ready: 0 = low, 1 = high, 2 = random per cycle (changes right after
   // the rising edge so the negedge monitor sees what the next edge sees).
   int   ready_mode = 1;
   logic rnd_bit = 1'b1;
   always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
   assign sccb_ready = (ready_mode == 2) ? rnd_bit : (ready_mode == 1);

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: records transfers and checks request stability under stall.
   int          cyc = 0;
   logic [15:0] got_w [$];
   int          got_t [$];
   logic        pv_stall = 1'b0;
   logic [15:0] pv_rd = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pv_stall = 1'b0;
      end else begin
         if (pv_stall) begin
            chk("hold_valid", 32'(sccb_valid), 32'd1);
            chk("hold_regdata", 32'({sccb_reg, sccb_data}), 32'(pv_rd));
         end
         if (sccb_valid && sccb_ready) begin
            got_w.push_back({sccb_reg, sccb_data});
            got_t.push_back(cyc);
         end
         pv_stall = sccb_valid && !sccb_ready;
         pv_rd    = {sccb_reg, sccb_data};
      end
   end

   // Reference model: expected writes, spacing between writes with ready
   // held high (3 cycles per write, 2+DC per delay entry), final address.
   logic [15:0] exp_w [$];
   int          exp_gap [$];
   int          exp_end;

   task automatic build_expect();
      int  k;
      bit  first;
      exp_w.delete();
      exp_gap.delete();
      exp_end = 255;
      k = 0;
      first = 1'b1;
      for (int a = 0; a < 256; a++) begin
         if (rom[a] == 16'hFFFF) begin
            exp_end = a;
            break;
         end else if (rom[a] == 16'hFFF0) begin
            k++;
         end else begin
            if (!first) exp_gap.push_back(3 + (2 + DC) * k);
            first = 1'b0;
            k = 0;
            exp_w.push_back(rom[a]);
         end
      end
   endtask

   function automatic logic [15:0] rand_entry();
      logic [7:0] r;
      logic [7:0] d;
      r = 8'($urandom_range(0, 254));
      d = 8'($urandom);
      return {r, d};
   endfunction

   task automatic load_directed();
      for (int a = 0; a < 256; a++) rom[a] = rand_entry();
      rom[0] = 16'h1280;
      rom[1] = 16'hFFF0;
      rom[2] = 16'h1101;
      rom[3] = 16'hFFFF;
   endtask

   task automatic pulse_start();
      logic was_done;
      @(negedge clk);
      was_done = done;
      #1 start = 1'b1;
      @(negedge clk);
      chk("start_busy", 32'(busy), 32'd1);
      if (was_done) begin
         chk("restart_done_clr", 32'(done), 32'd0);
         chk("restart_addr", 32'(rom_addr), 32'd0);
         chk("restart_rom_en", 32'(rom_en), 32'd1);
      end
      #1 start = 1'b0;
   endtask

   task automatic check_outputs_reset(input string tag);
      chk(tag, 32'({rom_en, rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done}), 32'd0);
   endtask

   // Runs the current ROM to completion and compares with the model.
   task automatic run_prog(input int rdy, input int stray_at);
      int i;
      build_expect();
      ready_mode = rdy;
      got_w.delete();
      got_t.delete();
      pulse_start();
      i = 0;
      while (!done && i < 20000) begin
         @(negedge clk);
         if (i == stray_at) begin
            #1 start = 1'b1;
         end else if (start) begin
            #1 start = 1'b0;
         end
         i++;
      end
      #1 start = 1'b0;
      chk("done_in_budget", 32'(i < 20000), 32'd1);
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_valid", 32'(sccb_valid), 32'd0);
      chk("end_addr", 32'(rom_addr), 32'(exp_end));
      chk("write_count", 32'(got_w.size()), 32'(exp_w.size()));
      if (got_w.size() == exp_w.size()) begin
         foreach (exp_w[j]) chk("write_val", 32'(got_w[j]), 32'(exp_w[j]));
         if (rdy == 1) begin
            for (int j = 1; j < got_t.size(); j++)
               chk("write_gap", 32'(got_t[j] - got_t[j-1]), 32'(exp_gap[j-1]));
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      load_directed();

      // Reset held; a start during reset must be ignored.
      repeat (2) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      check_outputs_reset("reset_values");
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("start_in_reset_ignored", 32'({busy, rom_en, done}), 32'd0);

      // Directed ROM, ready high: (12,80), 8 delay cycles, (11,01), done.
      run_prog(1, -1);
      // Start in DONE restarts; a stray start while busy has no effect.
      run_prog(1, 6);

      // Backpressure: ready low for the first 5 cycles of the first write.
      ready_mode = 0;
      got_w.delete();
      got_t.delete();
      pulse_start();
      w = 0;
      while (!sccb_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("bp_valid_seen", 32'(w < 50), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         chk("bp_valid", 32'(sccb_valid), 32'd1);
         chk("bp_regdata", 32'({sccb_reg, sccb_data}), 32'h1280);
         chk("bp_addr_hold", 32'(rom_addr), 32'd0);
         if (k == 5) begin
            @(posedge clk);
            #1 ready_mode = 1;
         end
         if (k < 6) @(negedge clk);
      end
      @(negedge clk);
      chk("bp_valid_drop", 32'(sccb_valid), 32'd0);
      chk("bp_addr_inc", 32'(rom_addr), 32'd1);
      chk("bp_single_xfer", 32'(got_w.size()), 32'd1);
      w = 0;
      while (!done && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_xfers", 32'(got_w.size()), 32'd2);

      // Reset in the 4th of 8 delay cycles, then replay from address 0.
      ready_mode = 1;
      pulse_start();
      w = 0;
      while (!(sccb_valid && sccb_ready) && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("rd_first_xfer", 32'(w < 50), 32'd1);
      repeat (6) @(negedge clk);
      chk("rd_in_delay", 32'({busy, rom_en, sccb_valid}), 32'b100);
      #2 rst_n = 1'b0;
      #1 check_outputs_reset("reset_mid_delay");
      @(negedge clk);
      #1 rst_n = 1'b1;
      run_prog(1, -1);

      // Random programs, alternating steady and random ready.
      for (int p = 0; p < 8; p++) begin
         int n;
         n = $urandom_range(0, 20);
         for (int a = 0; a < 256; a++) rom[a] = rand_entry();
         for (int a = 0; a < n; a++)
            if ($urandom_range(0, 4) == 0) rom[a] = 16'hFFF0;
         rom[n] = 16'hFFFF;
         run_prog((p % 2 == 0) ? 1 : 2, -1);
      end

      // No end marker: stops after address 255 without wrapping.
      for (int a = 0; a < 256; a++) rom[a] = rand_entry();
      rom[100] = 16'hFFF0;
      run_prog(1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
